// File: rtl/lisp_defs.sv
// Shared definitions for the cons-cell heap: sentinel values, cell type codes,
// operation and error encodings, and the heap controller state set.
package lisp_defs;

    // Word 0 is reserved; a pointer of 0 means "no cell".
    localparam int NIL = 0;

    // Header type codes. TYPE_FREE marks a cell that sits on the free list.
    localparam int TYPE_NUMBER = 1;
    localparam int TYPE_FREE   = 2;

    // A cell is header, car, cdr in consecutive words.
    localparam int CELL_WORDS = 3;

    typedef enum logic [2:0] {
        OP_READ    = 3'd0,
        OP_ALLOC   = 3'd1,
        OP_FREE    = 3'd2,
        OP_SET_CAR = 3'd3,
        OP_SET_CDR = 3'd4
    } mem_op_t;

    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_OOM         = 2'd1,
        ERR_BAD_ADDR    = 2'd2,
        ERR_DOUBLE_FREE = 2'd3
    } mem_err_t;

    // States are named after the RAM word being handled in that cycle.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHK,
        ST_POP,
        ST_WR_HDR,
        ST_WR_CAR,
        ST_WR_CDR,
        ST_RD_HDR,
        ST_RD_CAR,
        ST_RD_CDR,
        ST_FR_HDR,
        ST_FR_LNK,
        ST_DONE
    } heap_state_t;

endpackage

// File: rtl/cell_ram.sv
// Single-port synchronous RAM holding the cell words; reads return data one
// cycle after the address is presented. The array is named "memory" so a
// bench can preload or inspect it hierarchically.
module cell_ram #(
    parameter int WordWidth  = 16,
    parameter int MemorySize = 1024,
    parameter int AddrWidth  = $clog2(MemorySize)
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [AddrWidth-1:0] addr,
    input  logic [WordWidth-1:0] wdata,
    output logic [WordWidth-1:0] rdata
);

    logic [WordWidth-1:0] memory [MemorySize];

    // One access per cycle: either write the word or register the read data.
    // NOTE: the storage array and read register have no reset; RAM macros cannot clear on reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                memory[addr] <= wdata;
            end else begin
                rdata <= memory[addr];
            end
        end
    end

endmodule

// File: rtl/cell_heap.sv
// Cons-cell heap controller. Allocates three-word cells from a LIFO free list
// when one exists, otherwise from a bump pointer, and services read, free and
// in-place car/cdr updates against a single-port RAM, one access per cycle.
module cell_heap
    import lisp_defs::*;
#(
    parameter int WordWidth  = 16,
    parameter int TypeWidth  = 15,
    parameter int MemorySize = 1024,
    parameter int HeapStart  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  mem_op_t              op,
    input  logic [WordWidth-1:0] addr_in,
    input  logic [TypeWidth-1:0] data_type,
    input  logic [WordWidth-1:0] car_data,
    input  logic [WordWidth-1:0] cdr_data,
    output logic [TypeWidth-1:0] header_out,
    output logic [WordWidth-1:0] car_out,
    output logic [WordWidth-1:0] cdr_out,
    output logic [WordWidth-1:0] ptr,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output mem_err_t             err_code,
    output logic [WordWidth-1:0] cells_used
);

    localparam int AddrWidth = $clog2(MemorySize);

    localparam logic [WordWidth-1:0] Nil      = WordWidth'(NIL);
    localparam logic [TypeWidth-1:0] TypeFree = TypeWidth'(TYPE_FREE);
    localparam logic [WordWidth-1:0] CellStep = WordWidth'(CELL_WORDS);

    heap_state_t          state;
    mem_op_t              op_r;
    mem_err_t             err_r;
    logic [WordWidth-1:0] addr_r;
    logic [TypeWidth-1:0] type_r;
    logic [WordWidth-1:0] car_r;
    logic [WordWidth-1:0] cdr_r;
    logic [WordWidth-1:0] link_r;
    logic                 from_free_r;
    logic [WordWidth-1:0] bump;
    logic [WordWidth-1:0] free_head;

    logic                 ram_en;
    logic                 ram_we;
    logic [AddrWidth-1:0] ram_addr;
    logic [WordWidth-1:0] ram_wdata;
    logic [WordWidth-1:0] ram_rdata;

    logic                 accept;
    logic                 addr_ok;
    logic                 free_avail;
    logic                 oom;
    mem_err_t             accept_err;
    logic                 fin;
    mem_err_t             fin_err;

    cell_ram #(
        .WordWidth (WordWidth),
        .MemorySize(MemorySize),
        .AddrWidth (AddrWidth)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    // Request admission and the checks that can be decided before any RAM access.
    assign accept     = req && !busy;
    assign addr_ok    = (addr_in >= WordWidth'(HeapStart)) && (addr_in < bump);
    assign free_avail = (free_head != Nil);
    assign oom        = ({1'b0, bump} + {1'b0, CellStep}) > (WordWidth + 1)'(MemorySize);

    // Classify the incoming request: address range for cell targets, capacity for ALLOC.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        accept_err = ERR_NONE;
        case (op)
            OP_READ, OP_FREE, OP_SET_CAR, OP_SET_CDR: begin
                if (!addr_ok) accept_err = ERR_BAD_ADDR;
            end
            OP_ALLOC: begin
                if (!free_avail && oom) accept_err = ERR_OOM;
            end
            default: accept_err = ERR_BAD_ADDR;
        endcase
    end

    // RAM port: the first read is issued on the accepting edge, the rest follow the state.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (accept && accept_err == ERR_NONE) begin
            if (op == OP_READ || op == OP_FREE) begin
                ram_en   = 1'b1;
                ram_addr = AddrWidth'(addr_in);
            end else if (op == OP_ALLOC && free_avail) begin
                ram_en   = 1'b1;
                ram_addr = AddrWidth'(free_head + WordWidth'(1));
            end
        end
        case (state)
            ST_RD_HDR: begin
                ram_en   = 1'b1;
                ram_addr = AddrWidth'(addr_r + WordWidth'(1));
            end
            ST_RD_CAR: begin
                ram_en   = 1'b1;
                ram_addr = AddrWidth'(addr_r + WordWidth'(2));
            end
            ST_WR_HDR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = AddrWidth'(addr_r);
                ram_wdata = {1'b0, type_r};
            end
            ST_WR_CAR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = AddrWidth'(addr_r + WordWidth'(1));
                ram_wdata = car_r;
            end
            ST_WR_CDR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = AddrWidth'(addr_r + WordWidth'(2));
                ram_wdata = cdr_r;
            end
            ST_FR_HDR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = AddrWidth'(addr_r);
                ram_wdata = {1'b0, TypeFree};
            end
            ST_FR_LNK: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = AddrWidth'(addr_r + WordWidth'(1));
                ram_wdata = free_head;
            end
            default: ;
        endcase
    end

    // Decide whether the current state ends the operation, and with which outcome.
    always_comb begin
        fin     = 1'b0;
        fin_err = ERR_NONE;
        case (state)
            ST_CHK: begin
                if (err_r != ERR_NONE) begin
                    fin     = 1'b1;
                    fin_err = err_r;
                end else if (ram_rdata[TypeWidth-1:0] == TypeFree) begin
                    fin     = 1'b1;
                    fin_err = ERR_DOUBLE_FREE;
                end
            end
            ST_WR_CAR: fin = (op_r == OP_SET_CAR);
            ST_WR_CDR, ST_RD_CDR, ST_FR_LNK: fin = 1'b1;
            default: ;
        endcase
    end

    // Controller FSM: sequences the RAM accesses and owns all registered outputs.
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            op_r        <= OP_READ;
            err_r       <= ERR_NONE;
            addr_r      <= '0;
            type_r      <= '0;
            car_r       <= '0;
            cdr_r       <= '0;
            link_r      <= '0;
            from_free_r <= 1'b0;
            bump        <= WordWidth'(HeapStart);
            free_head   <= Nil;
            header_out  <= '0;
            car_out     <= '0;
            cdr_out     <= '0;
            ptr         <= Nil;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= ERR_NONE;
            cells_used  <= '0;
        end else begin
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
            case (state)
                ST_IDLE, ST_DONE: begin
                    state <= ST_IDLE;
                    if (accept) begin
                        busy        <= 1'b1;
                        op_r        <= op;
                        err_r       <= accept_err;
                        type_r      <= data_type;
                        car_r       <= car_data;
                        cdr_r       <= cdr_data;
                        from_free_r <= free_avail;
                        if (op == OP_ALLOC) begin
                            addr_r <= free_avail ? free_head : bump;
                        end else begin
                            addr_r <= addr_in;
                        end
                        if (accept_err != ERR_NONE) begin
                            state <= ST_CHK;
                        end else begin
                            case (op)
                                OP_READ:    state <= ST_RD_HDR;
                                OP_ALLOC:   state <= free_avail ? ST_POP : ST_WR_HDR;
                                OP_SET_CAR: state <= ST_WR_CAR;
                                OP_SET_CDR: state <= ST_WR_CDR;
                                default:    state <= ST_CHK;
                            endcase
                        end
                    end
                end
                ST_CHK:    state <= ST_FR_HDR;
                ST_POP: begin
                    link_r <= ram_rdata;
                    state  <= ST_WR_HDR;
                end
                ST_WR_HDR: state <= ST_WR_CAR;
                ST_WR_CAR: state <= ST_WR_CDR;
                ST_WR_CDR: begin
                    if (op_r == OP_ALLOC) begin
                        ptr        <= addr_r;
                        cells_used <= cells_used + WordWidth'(1);
                        if (from_free_r) begin
                            free_head <= link_r;
                        end else begin
                            bump <= bump + CellStep;
                        end
                    end
                end
                ST_RD_HDR: begin
                    header_out <= ram_rdata[TypeWidth-1:0];
                    state      <= ST_RD_CAR;
                end
                ST_RD_CAR: begin
                    car_out <= ram_rdata;
                    state   <= ST_RD_CDR;
                end
                ST_RD_CDR: cdr_out <= ram_rdata;
                ST_FR_HDR: state <= ST_FR_LNK;
                ST_FR_LNK: begin
                    free_head  <= addr_r;
                    cells_used <= cells_used - WordWidth'(1);
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (fin) begin
                state    <= ST_DONE;
                busy     <= 1'b0;
                done     <= 1'b1;
                error    <= (fin_err != ERR_NONE);
                err_code <= fin_err;
            end
        end
    end

endmodule

// File: tb/tb_cell_heap.sv
// Directed bench for cell_heap with a 16-word heap (cells at 1,4,7,10,13).
module tb_cell_heap;
    import lisp_defs::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           req;
    mem_op_t        op;
    logic [15:0]    addr_in;
    logic [14:0]    data_type;
    logic [15:0]    car_data;
    logic [15:0]    cdr_data;
    logic [14:0]    header_out;
    logic [15:0]    car_out;
    logic [15:0]    cdr_out;
    logic [15:0]    ptr;
    logic           busy;
    logic           done;
    logic           error;
    mem_err_t       err_code;
    logic [15:0]    cells_used;

    int total = 0;
    int bad   = 0;

    logic [15:0] snap [16];

    cell_heap #(
        .WordWidth (16),
        .TypeWidth (15),
        .MemorySize(16),
        .HeapStart (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op        (op),
        .addr_in   (addr_in),
        .data_type (data_type),
        .car_data  (car_data),
        .cdr_data  (cdr_data),
        .header_out(header_out),
        .car_out   (car_out),
        .cdr_out   (cdr_out),
        .ptr       (ptr),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (err_code),
        .cells_used(cells_used)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request and check busy, latency (edges after acceptance) and error result.
    // A negative exp_lat skips the latency comparison.
    task automatic issue(input string tag, input mem_op_t o, input logic [15:0] a,
                         input logic [15:0] c, input logic [15:0] d,
                         input int exp_lat, input mem_err_t exp_err);
        int lat;
        lat = 0;
        @(negedge clk);
        req       = 1'b1;
        op        = o;
        addr_in   = a;
        data_type = 15'(TYPE_NUMBER);
        car_data  = c;
        cdr_data  = d;
        @(posedge clk);
        #1;
        req = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
        else if (exp_lat >= 0) check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_err"}, {29'd0, error, err_code}, {29'd0, exp_err != ERR_NONE, exp_err});
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    task automatic take_snap();
        for (int i = 0; i < 16; i++) snap[i] = dut.u_ram.memory[i];
    endtask

    function automatic int snap_diffs();
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) if (dut.u_ram.memory[i] !== snap[i]) n++;
        return n;
    endfunction

    initial begin
        int n_done;
        rst = 1'b1; req = 1'b0; op = OP_READ; addr_in = '0;
        data_type = '0; car_data = '0; cdr_data = '0;
        for (int i = 0; i < 16; i++) dut.u_ram.memory[i] = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ptr", 32'(ptr), 32'd0);
        check("rst_cells", 32'(cells_used), 32'd0);
        check("rst_hdr", 32'(header_out), 32'd0);
        check("rst_err", {29'd0, error, err_code}, 32'd0);

        // 1: bump allocation and read-back
        issue("a1", OP_ALLOC, 16'h0, 16'hDEAD, 16'h0000, 3, ERR_NONE);
        check("a1_ptr", 32'(ptr), 32'd1);
        issue("a2", OP_ALLOC, 16'h0, 16'hBEEF, 16'h0000, 3, ERR_NONE);
        check("a2_ptr", 32'(ptr), 32'd4);
        issue("r4", OP_READ, 16'd4, 16'h0, 16'h0, 3, ERR_NONE);
        check("r4_hdr", 32'(header_out), 32'(TYPE_NUMBER));
        check("r4_car", 32'(car_out), 32'hBEEF);
        check("r4_cdr", 32'(cdr_out), 32'h0000);
        check("t1_cells", 32'(cells_used), 32'd2);

        // 2: free list reuse and double free
        issue("f1", OP_FREE, 16'd1, 16'h0, 16'h0, 3, ERR_NONE);
        check("f1_cells", 32'(cells_used), 32'd1);
        check("f1_mem_hdr", 32'(dut.u_ram.memory[1]), 32'(TYPE_FREE));
        check("f1_mem_lnk", 32'(dut.u_ram.memory[2]), 32'd0);
        issue("a3", OP_ALLOC, 16'h0, 16'hCAFE, 16'h0000, 4, ERR_NONE);
        check("a3_ptr", 32'(ptr), 32'd1);
        check("a3_cells", 32'(cells_used), 32'd2);
        issue("f2", OP_FREE, 16'd1, 16'h0, 16'h0, 3, ERR_NONE);
        check("f2_cells", 32'(cells_used), 32'd1);
        issue("f3", OP_FREE, 16'd1, 16'h0, 16'h0, -1, ERR_DOUBLE_FREE);
        check("f3_cells", 32'(cells_used), 32'd1);

        // 4: bad addresses (bump=7), no RAM change, results held
        take_snap();
        issue("bad_r0", OP_READ, 16'd0, 16'h0, 16'h0, 1, ERR_BAD_ADDR);
        issue("bad_r13", OP_READ, 16'd13, 16'h0, 16'h0, 1, ERR_BAD_ADDR);
        issue("bad_f0", OP_FREE, 16'd0, 16'h0, 16'h0, 1, ERR_BAD_ADDR);
        issue("bad_sc7", OP_SET_CAR, 16'd7, 16'h7777, 16'h0, 1, ERR_BAD_ADDR);
        check("bad_ram", 32'(snap_diffs()), 32'd0);
        check("bad_hold_car", 32'(car_out), 32'hBEEF);
        check("bad_cells", 32'(cells_used), 32'd1);

        // 3: fill, out of memory, reuse after free
        issue("a4", OP_ALLOC, 16'h0, 16'h1111, 16'h0000, 4, ERR_NONE);
        check("a4_ptr", 32'(ptr), 32'd1);
        issue("a5", OP_ALLOC, 16'h0, 16'h2222, 16'h0000, 3, ERR_NONE);
        check("a5_ptr", 32'(ptr), 32'd7);
        issue("a6", OP_ALLOC, 16'h0, 16'h3333, 16'h0000, 3, ERR_NONE);
        check("a6_ptr", 32'(ptr), 32'd10);
        issue("a7", OP_ALLOC, 16'h0, 16'h4444, 16'h0000, 3, ERR_NONE);
        check("a7_ptr", 32'(ptr), 32'd13);
        check("full_cells", 32'(cells_used), 32'd5);
        take_snap();
        issue("oom", OP_ALLOC, 16'h0, 16'h5555, 16'h0000, 1, ERR_OOM);
        check("oom_ptr", 32'(ptr), 32'd13);
        check("oom_cells", 32'(cells_used), 32'd5);
        check("oom_ram", 32'(snap_diffs()), 32'd0);
        issue("f7", OP_FREE, 16'd7, 16'h0, 16'h0, 3, ERR_NONE);
        check("f7_cells", 32'(cells_used), 32'd4);
        issue("a8", OP_ALLOC, 16'h0, 16'h6666, 16'h0000, 4, ERR_NONE);
        check("a8_ptr", 32'(ptr), 32'd7);
        check("a8_cells", 32'(cells_used), 32'd5);

        // 5: in-place updates
        issue("scdr4", OP_SET_CDR, 16'd4, 16'h0, 16'h0001, 1, ERR_NONE);
        issue("r4b", OP_READ, 16'd4, 16'h0, 16'h0, 3, ERR_NONE);
        check("r4b_hdr", 32'(header_out), 32'(TYPE_NUMBER));
        check("r4b_car", 32'(car_out), 32'hBEEF);
        check("r4b_cdr", 32'(cdr_out), 32'h0001);
        issue("scar10", OP_SET_CAR, 16'd10, 16'h1234, 16'hFFFF, 1, ERR_NONE);
        issue("r10", OP_READ, 16'd10, 16'h0, 16'h0, 3, ERR_NONE);
        check("r10_car", 32'(car_out), 32'h1234);
        check("r10_cdr", 32'(cdr_out), 32'h0000);

        // 5: req held while busy is ignored; exactly one done
        @(negedge clk);
        req = 1'b1; op = OP_READ; addr_in = 16'd4;
        @(posedge clk);
        #1;
        op = OP_ALLOC;
        n_done = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
            if (k == 2) req = 1'b0;
        end
        check("busy_req_dones", 32'(n_done), 32'd1);
        check("busy_req_cells", 32'(cells_used), 32'd5);
        check("busy_req_cdr", 32'(cdr_out), 32'h0001);

        // 6: reset in the middle of a free-list ALLOC
        issue("f13", OP_FREE, 16'd13, 16'h0, 16'h0, 3, ERR_NONE);
        @(negedge clk);
        req = 1'b1; op = OP_ALLOC; data_type = 15'(TYPE_NUMBER);
        car_data = 16'hABCD; cdr_data = 16'h5555;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("rst_mid_state", 32'(dut.state), 32'(ST_WR_CAR));
        rst = 1'b1;
        #1;
        check("amid_busy", 32'(busy), 32'd0);
        check("amid_done", 32'(done), 32'd0);
        check("amid_ptr", 32'(ptr), 32'd0);
        check("amid_cells", 32'(cells_used), 32'd0);
        check("amid_car", 32'(car_out), 32'd0);
        repeat (2) @(negedge clk);
        check("amid_ram_car", 32'(dut.u_ram.memory[14]), 32'd0);
        check("amid_ram_cdr", 32'(dut.u_ram.memory[15]), 32'd0);
        rst = 1'b0;
        issue("a9", OP_ALLOC, 16'h0, 16'h9999, 16'h0000, 3, ERR_NONE);
        check("a9_ptr", 32'(ptr), 32'd1);
        check("a9_cells", 32'(cells_used), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
